triple_checker: RTL
===================

# triple_checker

Iterative Pythagorean-triple verifier sitting directly downstream of the hypotenuse lookup stage. It accepts one operand set (x, y, h) per transaction and computes x² + y² and h² with a shared shift-add squarer. It reports whether the set is a valid triple, or flags a lookup miss when h is zero. Results are presented on a valid/ready output handshake so the top level can hold results for external readout.

## Interface
Parameters:
- W, 8, operand width (only 8 is supported).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept; high only in IDLE.
- x  in  W  first leg.
- y  in  W  second leg.
- h  in  W  hypotenuse from the lookup stage; 0 means lookup miss.
- out_valid  out  1  result available; held until accepted.
- out_ready  in  1  consumer accepts the result.
- match  out  1  x² + y² == h² and h != 0.
- miss  out  1  captured h was 0.
- sum_sq  out  2W+1  x² + y², zero-extended.
- hyp_sq  out  2W  h².
- pass_cnt  out  8  present only with TRIPLE_STATS_EN.
- fail_cnt  out  8  present only with TRIPLE_STATS_EN.

## Operation
- States: IDLE, SQ_X, SQ_Y, SQ_H, CMP, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, capture x, y and h into internal registers and go to SQ_X.
- SQ_X, SQ_Y, SQ_H:
  - Each state runs the squarer for exactly 8 cycles, one multiplier bit per cycle, LSB first.
  - Partial-product accumulator is 2W bits.
  - The x² result is stored into the sum register. The y² result is added to it at the end of SQ_Y; the 17-bit sum cannot overflow.
  - The h² result is stored into the hyp register.
- CMP (1 cycle):
  - Register match = (sum == hyp) && (h_cap != 0).
  - Register miss = (h_cap == 0).
  - Drive sum_sq and hyp_sq from the internal registers.
  - Set out_valid; go to DONE.
- DONE:
  - out_valid stays 1 and all result outputs are stable.
  - When out_ready is high, out_valid clears on that edge and the state returns to IDLE.
- While not in IDLE:
  - in_valid is ignored and operands are not sampled.
  - Input changes have no effect on the in-flight computation.
- An operand set of (0,0,0) gives miss = 1, match = 0.
- Result outputs keep their last values until the next CMP.
- Reset values: state IDLE; out_valid, match and miss 0; sum_sq and hyp_sq 0; counters 0.
- Reset mid-operation:
  - Any in-flight transaction is discarded and no result is produced.
  - in_ready is high on the first cycle after rst_n deasserts.

## Timing
- Let E0 be the capture edge (in_valid && in_ready).
- SQ_X occupies edges E1–E8, SQ_Y E9–E16, SQ_H E17–E24.
- CMP completes at E25, so out_valid is high after E25.
- Latency from capture to out_valid is 25 cycles.
- If out_ready is already high when out_valid rises, the result is accepted at E26 and in_ready is high after E26.
- Minimum transaction period is 27 cycles: 1 cycle in IDLE, 25 cycles of computation, and 1 cycle in DONE.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- Macro: TRIPLE_STATS_EN.
- Defined:
  - Adds the pass_cnt and fail_cnt ports and registers.
  - On each output acceptance (out_valid && out_ready): pass_cnt increments when match = 1; fail_cnt increments when match = 0 and miss = 0.
  - Misses are not counted.
  - Both counters saturate at 255 and reset to 0.
- Undefined: the ports and logic are absent and all other behaviour is identical.

## Structure
- Shared package triple_pkg:
  - State enum tc_state_t (IDLE, SQ_X, SQ_Y, SQ_H, CMP, DONE).
  - Constants TC_W = 8 and TC_SQ_CYCLES = 8.
  - Width localparams for the sum (17) and square (16) buses.
- Sub-module sq8_shift_add:
  - One sequential shift-add squarer with start, operand, done and result ports.
  - Instantiated once and reused for x, y and h.
  - Its cycle counter is driven by TC_SQ_CYCLES.

## Test plan
- (3,4,5), out_ready tied high: out_valid after exactly 25 cycles; match = 1, miss = 0, sum_sq = 25, hyp_sq = 25.
- (255,255,255): sum_sq = 130050, hyp_sq = 65025, match = 0; with stats enabled, fail_cnt = 1.
- (0,0,0), then (7,24,0): miss = 1 and match = 0 for both; no counter changes.
- (60,80,100) with out_ready held low for 10 cycles:
  - out_valid and the results stay stable.
  - in_ready stays 0, and a new in_valid with (5,12,13) is ignored.
  - After release, the next accepted set gives the result for (5,12,13).
- rst_n pulsed low during SQ_Y of (8,15,17):
  - Outputs return to reset values immediately and no out_valid follows.
  - Re-issuing (8,15,17) gives match = 1.
- Stats enabled: 300 back-to-back (3,4,5) transactions give pass_cnt = 255 (saturated) and fail_cnt = 0.

Source files
------------

// File: rtl/triple_checker_pkg.sv
// ============================================================================
// triple_pkg : shared types and constants for the Pythagorean-triple checker
// Rev 1.0
// ============================================================================
`default_nettype none

package triple_pkg;

  localparam int TC_W         = 8;
  localparam int TC_SQ_CYCLES = 8;
  localparam int TC_SUM_W     = 2 * TC_W + 1;
  localparam int TC_SQ_W      = 2 * TC_W;
  localparam int TC_CNT_W     = $clog2(TC_SQ_CYCLES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ_X = 3'd1,
    SQ_Y = 3'd2,
    SQ_H = 3'd3,
    CMP  = 3'd4,
    DONE = 3'd5
  } tc_state_t;

endpackage

`default_nettype wire

// File: rtl/triple_checker_if.sv
// ============================================================================
// triple_checker_if : operand/result handshake bundle (TRIPLE_STATS_EN adds counters)
// Rev 1.0
// ============================================================================
`default_nettype none

interface triple_checker_if #(
  parameter int W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic [W-1:0]     h;
  logic             out_valid;
  logic             out_ready;
  logic             match;
  logic             miss;
  logic [2*W:0]     sum_sq;
  logic [2*W-1:0]   hyp_sq;
`ifdef TRIPLE_STATS_EN
  logic [7:0]       pass_cnt;
  logic [7:0]       fail_cnt;
`endif

  modport master (
    output in_valid, x, y, h, out_ready,
    input  in_ready, out_valid, match, miss, sum_sq, hyp_sq
`ifdef TRIPLE_STATS_EN
    , input pass_cnt, fail_cnt
`endif
  );

  modport slave (
    input  in_valid, x, y, h, out_ready,
    output in_ready, out_valid, match, miss, sum_sq, hyp_sq
`ifdef TRIPLE_STATS_EN
    , output pass_cnt, fail_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/triple_checker_sq8_shift_add.sv
// ============================================================================
// sq8_shift_add : sequential shift-add squarer, one multiplier bit per cycle, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module sq8_shift_add
  import triple_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  input  wire logic [TC_W-1:0]    operand,
  output logic                    done,
  output logic [TC_SQ_W-1:0]      result
);

  localparam logic [TC_CNT_W-1:0] c_last = TC_CNT_W'(TC_SQ_CYCLES - 1);

  logic                 r_busy;
  logic [TC_CNT_W-1:0]  r_cnt;
  logic [TC_SQ_W-1:0]   r_mcand;
  logic [TC_W-1:0]      r_mplier;
  logic [TC_SQ_W-1:0]   r_acc;
  logic [TC_SQ_W-1:0]   w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The final step's sum is exposed combinationally so the caller can latch it on the done edge.
  assign done   = r_busy && (r_cnt == c_last);
  assign result = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{(TC_SQ_W-TC_W){1'b0}}, operand};
      r_mplier <= operand;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/triple_checker.sv
// ============================================================================
// triple_checker : iterative x^2 + y^2 == h^2 verifier with a shared squarer
// Optional counters under TRIPLE_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module triple_checker
  import triple_pkg::*;
#(
  parameter int W = TC_W
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  triple_checker_if.slave  bus
);

  tc_state_t             r_state;
  tc_state_t             w_state_next;
  logic [W-1:0]          r_y_cap;
  logic [W-1:0]          r_h_cap;
  logic [TC_SUM_W-1:0]   r_sum;
  logic [TC_SQ_W-1:0]    r_hyp;
  logic                  r_match;
  logic                  r_miss;
  logic [TC_SUM_W-1:0]   r_sum_sq;
  logic [TC_SQ_W-1:0]    r_hyp_sq;
  logic                  w_sq_start;
  logic [TC_W-1:0]       w_sq_operand;
  logic                  w_sq_done;
  logic [TC_SQ_W-1:0]    w_sq_result;

  sq8_shift_add u_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_sq_start),
    .operand (w_sq_operand),
    .done    (w_sq_done),
    .result  (w_sq_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // x goes straight from the bus into the squarer on the capture edge, so it is never stored.
  always_comb begin
    w_state_next = r_state;
    w_sq_start   = 1'b0;
    w_sq_operand = r_y_cap;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_next = SQ_X;
          w_sq_start   = 1'b1;
          w_sq_operand = bus.x;
        end
      end
      SQ_X: begin
        if (w_sq_done) begin
          w_state_next = SQ_Y;
          w_sq_start   = 1'b1;
          w_sq_operand = r_y_cap;
        end
      end
      SQ_Y: begin
        if (w_sq_done) begin
          w_state_next = SQ_H;
          w_sq_start   = 1'b1;
          w_sq_operand = r_h_cap;
        end
      end
      SQ_H: begin
        if (w_sq_done) begin
          w_state_next = CMP;
        end
      end
      CMP:     w_state_next = DONE;
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_cap  <= '0;
      r_h_cap  <= '0;
      r_sum    <= '0;
      r_hyp    <= '0;
      r_match  <= 1'b0;
      r_miss   <= 1'b0;
      r_sum_sq <= '0;
      r_hyp_sq <= '0;
    end else begin
      if (r_state == IDLE && bus.in_valid) begin
        r_y_cap <= bus.y;
        r_h_cap <= bus.h;
      end
      if (r_state == SQ_X && w_sq_done) begin
        r_sum <= TC_SUM_W'(w_sq_result);
      end
      if (r_state == SQ_Y && w_sq_done) begin
        r_sum <= r_sum + TC_SUM_W'(w_sq_result);
      end
      if (r_state == SQ_H && w_sq_done) begin
        r_hyp <= w_sq_result;
      end
      if (r_state == CMP) begin
        r_match  <= (r_sum == TC_SUM_W'(r_hyp)) && (r_h_cap != '0);
        r_miss   <= (r_h_cap == '0);
        r_sum_sq <= r_sum;
        r_hyp_sq <= r_hyp;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.match     = r_match;
  assign bus.miss      = r_miss;
  assign bus.sum_sq    = r_sum_sq;
  assign bus.hyp_sq    = r_hyp_sq;

`ifdef TRIPLE_STATS_EN
  logic [7:0] r_pass_cnt;
  logic [7:0] r_fail_cnt;
  logic       w_accept;

  assign w_accept = (r_state == DONE) && bus.out_ready;

  // Misses are deliberately excluded from both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (w_accept) begin
      if (r_match && r_pass_cnt != 8'hFF) begin
        r_pass_cnt <= r_pass_cnt + 8'd1;
      end
      if (!r_match && !r_miss && r_fail_cnt != 8'hFF) begin
        r_fail_cnt <= r_fail_cnt + 8'd1;
      end
    end
  end

  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
`endif

endmodule

`default_nettype wire
